// File: rtl/pxie_pkg.sv
// Shared constants, state encoding and header builder for the PXIE C2H path.
package pxie_pkg;

  localparam int C2H_WORD_W = 128;
  localparam logic [15:0] PXIE_HEAD_MAGIC = 16'heb9c;
  localparam logic [15:0] CMD_READCFG = 16'h1010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEAD,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } c2h_state_t;

  function automatic logic [C2H_WORD_W-1:0] make_header(input logic [15:0] len,
                                                        input logic [15:0] addr);
    return {64'd0, PXIE_HEAD_MAGIC, len, addr, CMD_READCFG};
  endfunction

endpackage

// File: rtl/pxie_c2h_fifo.sv
// Synchronous first-word fall-through FIFO; the head entry is always visible on dout.
module pxie_c2h_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 8
) (
  input  logic                       I_PXIE_CLK,
  input  logic                       I_Rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge I_PXIE_CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge I_PXIE_CLK) begin
    if (!I_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // The reader's credit scheme must never push into a full FIFO without a pop.
  overflow_chk: assert property (@(posedge I_PXIE_CLK) disable iff (!I_Rst_n)
                                 !(push && full && !pop));

endmodule

// File: rtl/pxie_c2h_reader.sv
// Reads a run of RAM words on a read-config request and streams them, behind a
// header word, to the C2H valid/ready interface.
module pxie_c2h_reader
  import pxie_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 16
) (
  input  logic                  I_PXIE_CLK,
  input  logic                  I_Rst_n,
  input  logic [15:0]           I_c2h_addr,
  input  logic [15:0]           I_c2h_len,
  input  logic                  I_c2h_en,
  output logic [ADDR_W-1:0]     O_ram_addr,
  output logic                  O_ram_rden,
  input  logic [C2H_WORD_W-1:0] I_ram_data,
  output logic [C2H_WORD_W-1:0] O_C2H_DATA,
  output logic                  O_C2H_DATA_VLD,
  input  logic                  I_C2H_READY,
  output logic                  O_C2H_LAST,
  output logic                  O_busy,
  output logic                  O_done,
  output logic                  O_req_drop
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  c2h_state_t state, state_nxt;

  logic              en_q;
  logic [15:0]       addr_q;
  logic [15:0]       len_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [16:0]       issued_cnt;
  logic [16:0]       acc_cnt;
  logic [16:0]       frame_words;
  logic [RD_LAT-1:0] rd_pipe;
  logic [RD_LAT-1:0] last_pipe;
  logic              req_drop_q;

  logic              en_rise;
  logic              accept;
  logic              rden;
  logic              rden_last;
  logic              head_push;
  logic              pop_fire;
  logic              fifo_push;
  logic [C2H_WORD_W:0] fifo_din;
  logic [C2H_WORD_W:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     inflight;
  logic [CW:0]       credit_used;

  assign en_rise     = I_c2h_en & ~en_q;
  assign accept      = en_rise && (state == ST_IDLE);
  assign frame_words = {1'b0, len_q} + 17'd1;
  assign pop_fire    = I_C2H_READY && !fifo_empty;
  assign head_push   = (state == ST_HEAD) && !fifo_full;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + {{(CW-1){1'b0}}, rd_pipe[i]};
  end

  // Reads in flight already own a FIFO slot, so the sum never exceeds the depth.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign rden        = (state == ST_READ) && (issued_cnt < {1'b0, len_q}) &&
                       (credit_used < (CW+1)'(FIFO_DEPTH));
  assign rden_last   = rden && ((issued_cnt + 17'd1) == {1'b0, len_q});

  always_comb begin
    fifo_push = rd_pipe[RD_LAT-1];
    fifo_din  = {last_pipe[RD_LAT-1], I_ram_data};
    if (head_push) begin
      fifo_push = 1'b1;
      fifo_din  = {(len_q == 16'd0), make_header(len_q, addr_q)};
    end
  end

  always_ff @(posedge I_PXIE_CLK) begin
    if (!I_Rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = ST_HEAD;
      ST_HEAD:  if (!fifo_full) state_nxt = (len_q == 16'd0) ? ST_DRAIN : ST_READ;
      ST_READ:  if (rden_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if ((acc_cnt == frame_words) ||
                    (pop_fire && ((acc_cnt + 17'd1) == frame_words))) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_PXIE_CLK) begin
    if (!I_Rst_n) begin
      en_q       <= 1'b0;
      req_drop_q <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      rd_addr    <= '0;
      issued_cnt <= '0;
      acc_cnt    <= '0;
      rd_pipe    <= '0;
      last_pipe  <= '0;
    end else begin
      en_q       <= I_c2h_en;
      req_drop_q <= en_rise && (state != ST_IDLE);
      if (accept) begin
        addr_q     <= I_c2h_addr;
        len_q      <= I_c2h_len;
        rd_addr    <= ADDR_W'(I_c2h_addr);
        issued_cnt <= '0;
        acc_cnt    <= '0;
      end else begin
        if (rden) begin
          rd_addr    <= rd_addr + 1'b1;
          issued_cnt <= issued_cnt + 17'd1;
        end
        if (pop_fire && (state != ST_IDLE)) acc_cnt <= acc_cnt + 17'd1;
      end
      rd_pipe[0]   <= rden;
      last_pipe[0] <= rden_last;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe[i]   <= rd_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  pxie_c2h_fifo #(
    .WIDTH (C2H_WORD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .I_PXIE_CLK (I_PXIE_CLK),
    .I_Rst_n    (I_Rst_n),
    .push       (fifo_push),
    .din        (fifo_din),
    .pop        (I_C2H_READY),
    .dout       (fifo_dout),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign O_ram_addr     = rd_addr;
  assign O_ram_rden     = rden;
  assign O_C2H_DATA_VLD = !fifo_empty;
  assign O_C2H_DATA     = fifo_empty ? '0 : fifo_dout[C2H_WORD_W-1:0];
  assign O_C2H_LAST     = !fifo_empty && fifo_dout[C2H_WORD_W];
  assign O_busy         = (state == ST_HEAD) || (state == ST_READ) || (state == ST_DRAIN);
  assign O_done         = (state == ST_DONE);
  assign O_req_drop     = req_drop_q;

endmodule

// File: tb/tb_pxie_c2h_reader.sv
// Directed bench for pxie_c2h_reader: RAM model returns mem[a]=a, frames checked word by word.
module tb_pxie_c2h_reader;

  localparam int RD_LAT = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  c2h_addr;
  logic [15:0]  c2h_len;
  logic         c2h_en;
  logic [15:0]  ram_addr;
  logic         ram_rden;
  logic [127:0] ram_data;
  logic [127:0] c2h_data;
  logic         c2h_vld;
  logic         c2h_ready;
  logic         c2h_last;
  logic         busy;
  logic         done;
  logic         req_drop;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt, drop_cnt, rden_cnt, done_cyc, last_cyc;
  logic [128:0] out_q[$];
  logic [15:0]  addr_q[$];
  logic [127:0] ram_pipe [RD_LAT];

  always #5 clk = ~clk;

  pxie_c2h_reader dut (
    .I_PXIE_CLK     (clk),
    .I_Rst_n        (rst_n),
    .I_c2h_addr     (c2h_addr),
    .I_c2h_len      (c2h_len),
    .I_c2h_en       (c2h_en),
    .O_ram_addr     (ram_addr),
    .O_ram_rden     (ram_rden),
    .I_ram_data     (ram_data),
    .O_C2H_DATA     (c2h_data),
    .O_C2H_DATA_VLD (c2h_vld),
    .I_C2H_READY    (c2h_ready),
    .O_C2H_LAST     (c2h_last),
    .O_busy         (busy),
    .O_done         (done),
    .O_req_drop     (req_drop)
  );

  // RAM model with RD_LAT-cycle read latency, contents equal to the address
  always @(posedge clk) begin
    ram_pipe[0] <= ram_rden ? {112'd0, ram_addr} : 128'd0;
    for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign ram_data = ram_pipe[RD_LAT-1];

  always @(posedge clk) begin
    cyc++;
    if (rst_n) begin
      if (c2h_vld && c2h_ready) begin
        out_q.push_back({c2h_last, c2h_data});
        if (c2h_last) last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (req_drop) drop_cnt++;
      if (ram_rden) begin
        rden_cnt++;
        addr_q.push_back(ram_addr);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [128:0] got, input logic [128:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] l,
                               input int mode, input int drop_at);
    int n;
    out_q.delete();
    addr_q.delete();
    done_cnt = 0;
    drop_cnt = 0;
    rden_cnt = 0;
    @(negedge clk);
    c2h_addr  = a;
    c2h_len   = l;
    c2h_en    = 1'b1;
    c2h_ready = 1'b1;
    @(negedge clk);
    c2h_en = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n++;
      c2h_ready = (mode == 0) ? 1'b1 : ((n % 3) == 0);
      c2h_en    = (drop_at != 0 && n == drop_at);
    end
    c2h_en = 1'b0;
    if (done_cnt == 0) checkOutput("timeout", 129'd0, 129'd1);
    c2h_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic checkFrame(input string tag, input logic [15:0] a, input logic [15:0] l);
    logic [128:0] exp;
    logic [15:0]  wa;
    int           nw;
    nw = int'(l) + 1;
    checkOutput({tag, "_nwords"}, 129'(out_q.size()), 129'(nw));
    for (int i = 0; i < nw && i < out_q.size(); i++) begin
      if (i == 0) begin
        exp = {(l == 16'd0), 64'd0, 16'heb9c, l, a, 16'h1010};
      end else begin
        wa  = a + 16'(i - 1);
        exp = {(i == nw - 1), 112'd0, wa};
      end
      checkOutput($sformatf("%s_w%0d", tag, i), out_q[i], exp);
    end
    checkOutput({tag, "_done"}, 129'(done_cnt), 129'd1);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_vld"},  129'(c2h_vld),  129'd0);
    checkOutput({tag, "_data"}, 129'(c2h_data), 129'd0);
    checkOutput({tag, "_last"}, 129'(c2h_last), 129'd0);
    checkOutput({tag, "_busy"}, 129'(busy),     129'd0);
    checkOutput({tag, "_done"}, 129'(done),     129'd0);
    checkOutput({tag, "_drop"}, 129'(req_drop), 129'd0);
    checkOutput({tag, "_rden"}, 129'(ram_rden), 129'd0);
    checkOutput({tag, "_addr"}, 129'(ram_addr), 129'd0);
  endtask

  initial begin
    int vld_seen;
    rst_n     = 1'b0;
    c2h_addr  = '0;
    c2h_len   = '0;
    c2h_en    = 1'b0;
    c2h_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(16'h0010, 16'd4, 0, 0);
    checkFrame("basic", 16'h0010, 16'd4);
    checkOutput("basic_done_lat", 129'(done_cyc), 129'(last_cyc + 1));
    checkOutput("basic_rden", 129'(rden_cnt), 129'd4);

    applyStimulus(16'h0020, 16'd0, 0, 0);
    checkFrame("zero", 16'h0020, 16'd0);
    checkOutput("zero_rden", 129'(rden_cnt), 129'd0);

    applyStimulus(16'h0100, 16'd20, 1, 0);
    checkFrame("bp", 16'h0100, 16'd20);
    checkOutput("bp_rden", 129'(rden_cnt), 129'd20);

    applyStimulus(16'hFFFE, 16'd4, 0, 0);
    checkOutput("wrap_n", 129'(addr_q.size()), 129'd4);
    if (addr_q.size() == 4) begin
      checkOutput("wrap_a0", 129'(addr_q[0]), 129'h0FFFE);
      checkOutput("wrap_a1", 129'(addr_q[1]), 129'h0FFFF);
      checkOutput("wrap_a2", 129'(addr_q[2]), 129'h00000);
      checkOutput("wrap_a3", 129'(addr_q[3]), 129'h00001);
    end
    checkFrame("wrap", 16'hFFFE, 16'd4);

    applyStimulus(16'h0040, 16'd12, 0, 5);
    checkFrame("busy", 16'h0040, 16'd12);
    checkOutput("busy_drop", 129'(drop_cnt), 129'd1);
    applyStimulus(16'h0050, 16'd3, 0, 0);
    checkFrame("after", 16'h0050, 16'd3);
    checkOutput("after_drop", 129'(drop_cnt), 129'd0);

    // Reset pulse while the frame is reading
    done_cnt = 0;
    @(negedge clk);
    c2h_addr = 16'h0200;
    c2h_len  = 16'd20;
    c2h_en   = 1'b1;
    @(negedge clk);
    c2h_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkIdleOutputs("midrst");
    vld_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (c2h_vld) vld_seen++;
    end
    checkOutput("midrst_vld", 129'(vld_seen), 129'd0);
    checkOutput("midrst_done", 129'(done_cnt), 129'd0);
    applyStimulus(16'h0300, 16'd5, 0, 0);
    checkFrame("clean", 16'h0300, 16'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pxie_c2h_reader.md
Name: pxie_c2h_reader

Overview:
- Downstream consumer of the PXIE command decoder's read-config request (c2h_addr / c2h_len / c2h_en).
- On a request, reads c2h_len consecutive 128-bit words from the system RAM read port, starting at c2h_addr.
- Frames the read words behind one header word and streams them to the PXIE card-to-host (C2H) path using a valid/ready handshake.
- Absorbs RAM read latency and host back-pressure with a small internal FIFO.

Parameters:
- RD_LAT, 2, RAM read latency in cycles from O_ram_rden to valid I_ram_data (range 1..4).
- FIFO_DEPTH, 8, output buffer depth in words (power of 2, must be greater than RD_LAT+1).
- ADDR_W, 16, RAM word-address width.

Ports:
- I_PXIE_CLK  in  1  sole clock.
- I_Rst_n  in  1  reset, synchronous, active-low.
- I_c2h_addr  in  16  start word address, sampled when I_c2h_en is accepted.
- I_c2h_len  in  16  number of data words, sampled when I_c2h_en is accepted.
- I_c2h_en  in  1  request strobe (one or more cycles high).
- O_ram_addr  out  ADDR_W  RAM read address.
- O_ram_rden  out  1  RAM read enable.
- I_ram_data  in  128  RAM read data, valid RD_LAT cycles after rden.
- O_C2H_DATA  out  128  output word.
- O_C2H_DATA_VLD  out  1  output word valid.
- I_C2H_READY  in  1  downstream accepts the word when both VLD and READY are high.
- O_C2H_LAST  out  1  marks the final word of the frame.
- O_busy  out  1  a frame is in progress.
- O_done  out  1  one-cycle pulse after the last word is accepted.
- O_req_drop  out  1  one-cycle pulse when a request arrives while busy.

Behaviour:
- Reset (I_Rst_n low at a clock edge):
  - All outputs are 0, FIFO is emptied, state goes to ST_IDLE, and the read-latency pipeline is cleared.
  - A reset mid-frame abandons the frame; no LAST or done is produced.
- Request acceptance:
  - A request is accepted on a rising edge of I_c2h_en detected in ST_IDLE (en high now, low on the previous cycle).
  - On acceptance, addr and len are latched and O_busy goes high on the next cycle.
  - A rising edge while not in ST_IDLE is ignored and pulses O_req_drop.
  - Holding I_c2h_en high does not retrigger a request.
- State machine:
  - ST_IDLE -> ST_HEAD on accept.
  - ST_HEAD: push the header word into the FIFO when it is not full.
    - Header: [127:64]=0, [63:48]=16'heb9c, [47:32]=len, [31:16]=addr, [15:0]=16'h1010.
    - LAST is set on the header if len==0.
    - Then go to ST_READ, or to ST_DRAIN if len==0.
  - ST_READ: issue one read per cycle while (FIFO count + outstanding reads) < FIFO_DEPTH.
    - O_ram_addr increments modulo 2^ADDR_W; wrap from 16'hFFFF to 0 is legal.
    - After len reads have been issued -> ST_DRAIN.
  - ST_DRAIN: wait until all outstanding reads have landed and the FIFO is empty with its last word accepted -> ST_DONE.
  - ST_DONE: O_done pulses for one cycle, O_busy drops -> ST_IDLE.
- Read pipeline:
  - A shift register of RD_LAT valid bits tracks reads in flight.
  - Returned data is pushed unconditionally. The credit rule above guarantees the FIFO never overflows; an overflow is a design error and is flagged by an assertion.
  - The tag bit for the final read carries LAST through the FIFO alongside the data.
- Output:
  - O_C2H_DATA_VLD = FIFO not empty; data and LAST come from the FIFO head (first-word fall-through).
  - Outputs are held stable while VLD is high and READY is low.
  - A push and a pop in the same cycle are both allowed; count is unchanged.
- Throughput: with READY held high, a frame of len words completes in len+1 transfers with no bubbles after the first RD_LAT+2 cycles.
- Counters: the issued-word counter and the accepted-word counter are 17 bits, so len=16'hFFFF does not wrap the count.

Decomposition:
- Shared package pxie_pkg holds:
  - PXIE_HEAD_MAGIC = 16'heb9c
  - CMD_READCFG = 16'h1010
  - the state encoding constants
  - C2H_WORD_W = 128
- One sub-module, pxie_c2h_fifo: synchronous FIFO with first-word fall-through.
  - Parameters: WIDTH = 129 (data + LAST) and DEPTH.
  - Outputs: full, empty, count.

Test Plan:
- Basic read, READY always 1:
  - Stimulus: RAM preloaded with mem[a]=a, addr=16'h0010, len=4, en pulse.
  - Required: header 64'h..._eb9c_0004_0010_1010, then data 0x10..0x13; LAST on the 0x13 word; O_done one cycle later.
- Zero length:
  - Stimulus: len=0.
  - Required: only the header is sent, with LAST=1, then O_done. No O_ram_rden ever asserts.
- Back-pressure:
  - Stimulus: len=20; READY toggles on a 1-in-3 pattern.
  - Required: all 21 words arrive in order with none dropped or duplicated; the FIFO never overflows; O_ram_rden stalls while credits are exhausted.
- Address wrap:
  - Stimulus: addr=16'hFFFE, len=4.
  - Required: RAM addresses FFFE, FFFF, 0000, 0001, in that order.
- Request while busy:
  - Stimulus: a second en rising edge mid-frame.
  - Required: O_req_drop pulses once and the first frame completes unchanged. A subsequent request after O_done is served normally.
- Reset mid-frame:
  - Stimulus: I_Rst_n=0 for one cycle during ST_READ.
  - Required: all outputs 0 on the next edge and VLD stays 0 afterwards; a new request then yields a clean frame.
